// File: rtl/vv_add_elem_seq.sv
// Element sequencer and adder stage for the vv_add engine: takes a vector length,
// adds (a, b) pairs from a valid/ready stream and emits registered sums with index/last flags.
module vv_add_elem_seq #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [IDX_W-1:0]        cfg_last_idx,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    out_carry,
    output logic [(2**IDX_W)-1:0]   done_mask,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_ELEM = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      last_idx_r;
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_data_r;
    logic [IDX_W-1:0]      out_idx_r;
    logic                  out_last_r;
    logic                  out_carry_r;
    logic [NUM_ELEM-1:0]   done_mask_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  out_hs_s;
    logic                  last_hit_s;
    logic [DATA_W:0]       sum_s;
    logic [NUM_ELEM-1:0]   idx_onehot_s;

    // One-hot decode of the current element index, used to accumulate the completion mask.
    function automatic logic [NUM_ELEM-1:0] idx_decode(input logic [IDX_W-1:0] idx);
        return {{(NUM_ELEM-1){1'b0}}, 1'b1} << idx;
    endfunction

    // The single output register frees up either when empty or when it is being drained this cycle.
    assign in_ready_s   = (state_r == ST_RUN) && (!out_valid_r || out_ready);
    assign accept_s     = in_valid && in_ready_s;
    assign out_hs_s     = out_valid_r && out_ready;
    assign last_hit_s   = (idx_r == last_idx_r);
    assign sum_s        = {1'b0, in_a} + {1'b0, in_b};
    assign idx_onehot_s = idx_decode(idx_r);

    assign cfg_ready = (state_r == ST_IDLE);
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign out_carry = out_carry_r;
    assign done_mask = done_mask_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Sequencer FSM, output register and completion mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            last_idx_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_idx_r   <= {IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            out_carry_r <= 1'b0;
            done_mask_r <= {NUM_ELEM{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // A new accept reloads the register even when the old result leaves this cycle.
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sum_s[DATA_W-1:0];
                out_carry_r <= sum_s[DATA_W];
                out_idx_r   <= idx_r;
                out_last_r  <= last_hit_s;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        last_idx_r  <= cfg_last_idx;
                        idx_r       <= {IDX_W{1'b0}};
                        done_mask_r <= {NUM_ELEM{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        done_mask_r <= done_mask_r | idx_onehot_s;
                        if (last_hit_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            idx_r   <= idx_r + IDX_ONE;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vv_add_elem_seq.sv
// Self-checking bench for vv_add_elem_seq: random and directed vectors compared against
// a transaction-level reference (operand tables, expected-sum arithmetic, result order).
module tb_vv_add_elem_seq;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 7;
    localparam int NUM    = 128;
    localparam int BUDGET = 3000;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_last_idx;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_carry;
    logic [NUM-1:0]    done_mask;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] op_a [NUM];
    logic [DATA_W-1:0] op_b [NUM];

    // Reference: phase (0 idle, 1 run, 2 drain, 3 done), next element, held result index
    int             ph;
    int             nxt;
    int             vlast;
    int             held;
    bit             held_v;
    logic [NUM-1:0] ref_mask;
    int             next_out;
    int             done_seen;

    vv_add_elem_seq #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_last_idx(cfg_last_idx),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_carry(out_carry),
        .done_mask(done_mask), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        ph = 0; nxt = 0; vlast = 0; held = 0; held_v = 1'b0; ref_mask = '0;
    endtask

    // One clock: check outputs against the reference, advance the reference, move to next negedge.
    task automatic tick();
        bit     rdy;
        bit     acc;
        bit     hs;
        longint s;
        #1;
        rdy = (ph == 1) && (!held_v || out_ready);
        chk("cfg_ready", cfg_ready, ph == 0);
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 3);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, held_v);
        chk("done_mask", done_mask, ref_mask);
        if (held_v) begin
            s = longint'(op_a[held]) + longint'(op_b[held]);
            chk("out_data", out_data, s % (64'd1 << 32));
            chk("out_carry", out_carry, s >= (64'd1 << 32));
            chk("out_idx", out_idx, held);
            chk("out_last", out_last, held == vlast);
        end
        if (done) done_seen++;
        hs  = held_v && out_ready;
        acc = (ph == 1) && in_valid && rdy;
        if (rst) begin
            ref_reset();
        end else begin
            if (hs) begin
                chk("order", out_idx, next_out);
                next_out++;
            end
            if (acc) begin
                ref_mask[nxt] = 1'b1;
                held   = nxt;
                held_v = 1'b1;
            end else if (hs) begin
                held_v = 1'b0;
            end
            case (ph)
                0: if (cfg_valid) begin vlast = int'(cfg_last_idx); nxt = 0; ref_mask = '0; ph = 1; end
                1: if (acc) begin if (nxt == vlast) ph = 2; else nxt++; end
                2: if (hs) ph = 3;
                default: ph = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_carry", out_carry, 0);
    endtask

    task automatic fill_random(input int last);
        for (int k = 0; k <= last; k++) begin
            op_a[k] = $urandom;
            op_b[k] = $urandom;
        end
    endtask

    // mode 0: full throughput, 1: out_ready 1,0,0 repeating, 2: random valid/ready
    task automatic run_vec(input int last, input int mode, input bit inject_cfg, input int rst_at);
        int             cyc;
        logic [NUM-1:0] exp_mask;
        next_out  = 0;
        done_seen = 0;
        cfg_valid    = 1'b1;
        cfg_last_idx = IDX_W'(last);
        in_valid     = 1'b1;
        in_a         = $urandom;
        in_b         = $urandom;
        out_ready    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cyc = 0;
        while (ph != 0 && cyc < BUDGET) begin
            cyc++;
            case (mode)
                0: begin in_valid = 1'b1; out_ready = 1'b1; end
                1: begin in_valid = 1'b1; out_ready = (cyc % 3 == 1); end
                default: begin in_valid = ($urandom_range(0, 3) != 0); out_ready = $urandom_range(0, 1); end
            endcase
            in_a = (ph == 1) ? op_a[nxt] : $urandom;
            in_b = (ph == 1) ? op_b[nxt] : $urandom;
            cfg_valid    = inject_cfg && (cyc % 5 == 2);
            cfg_last_idx = IDX_W'((last + 3) % NUM);
            if (rst_at >= 0 && ph == 1 && nxt == rst_at) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        cfg_valid = 1'b0;
        chk("no_timeout", cyc < BUDGET, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (rst_at >= 0) begin
            chk("rst_mask", done_mask, 0);
            chk_reset_outputs();
        end else begin
            exp_mask = (128'd1 << (last + 1)) - 128'd1;
            chk("final_mask", done_mask, exp_mask);
            chk("done_pulses", done_seen, 1);
            chk("result_count", next_out, last + 1);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_last_idx = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        ref_reset();
        @(negedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;

        fill_random(9);
        run_vec(9, 0, 1'b0, 4);

        op_a[0] = 32'd1; op_b[0] = 32'd2;
        op_a[1] = 32'd3; op_b[1] = 32'd4;
        op_a[2] = 32'd5; op_b[2] = 32'd6;
        op_a[3] = 32'd7; op_b[3] = 32'd8;
        run_vec(3, 0, 1'b0, -1);

        op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0002;
        run_vec(0, 0, 1'b0, -1);

        fill_random(5);
        run_vec(5, 1, 1'b0, -1);

        fill_random(127);
        run_vec(127, 2, 1'b0, -1);

        fill_random(6);
        run_vec(6, 2, 1'b1, -1);
        fill_random(2);
        run_vec(2, 0, 1'b0, -1);

        fill_random(20);
        run_vec(20, 2, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
